wb_regfile: RTL and testbench

Write-back stage plus architectural register file of the pipelined CPU, consuming the MEM/WB pipeline register outputs.
- Selects ALU result or memory load data, then writes the 32x32 register file on the rising clock edge.
- Serves two combinational read ports to the ID stage.
- Exports the selected write-back value and enable to the EX forwarding unit.
- Keeps a retired-write counter for performance and debug.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/wb_mux.sv | 13 +
 rtl/wb_regfile.sv | 72 +++++++
 tb/tb_wb_regfile.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath sizes and the 2-bit write-back control word
// carried by MEM/WB and produced by the control unit.
package cpu_pkg;

    localparam int DATA_W      = 32;
    localparam int REG_NUM     = 32;
    localparam int REG_AW      = $clog2(REG_NUM);
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    // Field order matches the WB_REGWRITE / WB_MEMTOREG bit indices.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back select: load data when mem_to_reg is set, otherwise the ALU result.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = mem_to_reg ? mem_data : result;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file with a retired-write counter.
// Optional write-first read bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int REG_NUM = cpu_pkg::REG_NUM,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 WB_in,
    input  logic [$clog2(REG_NUM)-1:0] RdAddr_in,
    input  logic [DATA_W-1:0]          Result_in,
    input  logic [DATA_W-1:0]          MemReadData_in,
    input  logic [$clog2(REG_NUM)-1:0] RsAddr,
    input  logic [$clog2(REG_NUM)-1:0] RtAddr,
    output logic [DATA_W-1:0]          RsData,
    output logic [DATA_W-1:0]          RtData,
    output logic [DATA_W-1:0]          WbData_out,
    output logic                       WbEn_out,
    output logic [CNT_W-1:0]           WrCount
);

    import cpu_pkg::*;

    wb_ctrl_t          wb_ctrl;
    logic [DATA_W-1:0] regs [REG_NUM];

    assign wb_ctrl = WB_in;

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .mem_to_reg (wb_ctrl.mem_to_reg),
        .result     (Result_in),
        .mem_data   (MemReadData_in),
        .wb_data    (WbData_out)
    );

    // R0 is hardwired: a write to it is not a write and is not counted.
    assign WbEn_out = wb_ctrl.reg_write && (RdAddr_in != '0);

    // NOTE: the whole array is in the async reset because every register must read 0
    // while rst is high; this costs a reset-capable flop per bit instead of a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
            WrCount <= '0;
        end else if (WbEn_out) begin
            regs[RdAddr_in] <= WbData_out;
            WrCount         <= WrCount + CNT_W'(1);
        end
    end

    // NOTE: each output gets its array value first and is then optionally overridden,
    // so every path assigns it and no latch is inferred.
    always_comb begin
        RsData = (RsAddr == '0) ? '0 : regs[RsAddr];
        RtData = (RtAddr == '0) ? '0 : regs[RtAddr];
`ifdef WB_BYPASS_EN
        // WbEn_out already excludes R0, so address 0 never picks up the bypass.
        if (WbEn_out && (RsAddr == RdAddr_in)) begin
            RsData = WbData_out;
        end
        if (WbEn_out && (RtAddr == RdAddr_in)) begin
            RtData = WbData_out;
        end
`else
        // Pre-write contents are returned in the write cycle; hazard logic covers it.
`endif
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: stimulus queues expected values, a negedge monitor checks them.
module tb_wb_regfile;

    localparam int CNT_W = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_RS = 0, S_RT = 1, S_WBD = 2, S_WBEN = 3, S_CNT = 4;

    logic             clk, rst;
    logic [1:0]       wb;
    logic [4:0]       rd_addr, rs_addr, rt_addr;
    logic [31:0]      result, mem_data;
    logic [31:0]      rs_data, rt_data, wb_data;
    logic             wb_en;
    logic [CNT_W-1:0] wr_count;

    int          checks = 0;
    int          errors = 0;
    int          q_sig  [$];
    logic [31:0] q_val  [$];
    string       q_name [$];

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_in          (wb),
        .RdAddr_in      (rd_addr),
        .Result_in      (result),
        .MemReadData_in (mem_data),
        .RsAddr         (rs_addr),
        .RtAddr         (rt_addr),
        .RsData         (rs_data),
        .RtData         (rt_data),
        .WbData_out     (wb_data),
        .WbEn_out       (wb_en),
        .WrCount        (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            S_RS:    return rs_data;
            S_RT:    return rt_data;
            S_WBD:   return wb_data;
            S_WBEN:  return {31'b0, wb_en};
            default: return {{(32-CNT_W){1'b0}}, wr_count};
        endcase
    endfunction

    // Monitor: everything queued during the current cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (q_sig.size() > 0) begin
            check(q_name.pop_front(), sample(q_sig.pop_front()), q_val.pop_front());
        end
    end

    task automatic expect_val(input int sig, input logic [31:0] val, input string name);
        q_sig.push_back(sig);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    task automatic drive(input logic r, input logic [1:0] w, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] mem,
                         input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk);
        #1;
        rst      = r;
        wb       = w;
        rd_addr  = rd;
        result   = res;
        mem_data = mem;
        rs_addr  = rs;
        rt_addr  = rt;
    endtask

    initial begin
        rst = 1'b0; wb = 2'b00; rd_addr = '0; result = '0; mem_data = '0;
        rs_addr = '0; rt_addr = '0;
        #2 rst = 1'b1;

        drive(1, 2'b00, 0, 0, 0, 5, 9);
        expect_val(S_RS, 32'h0, "reset_rs");
        expect_val(S_RT, 32'h0, "reset_rt");
        expect_val(S_CNT, 32'h0, "reset_cnt");

        // ALU write-back to r5
        drive(0, 2'b10, 5, 32'h1234_5678, 32'hCAFE_0000, 5, 0);
        expect_val(S_WBEN, 32'h1, "alu_en");
        expect_val(S_WBD, 32'h1234_5678, "alu_wbdata");
        expect_val(S_RS, BYP ? 32'h1234_5678 : 32'h0, "alu_rs_same_cycle");
        expect_val(S_CNT, 32'h0, "alu_cnt_before");

        // Load write-back to r7
        drive(0, 2'b11, 7, 32'h0, 32'hDEAD_BEEF, 5, 7);
        expect_val(S_RS, 32'h1234_5678, "alu_r5");
        expect_val(S_CNT, 32'h1, "alu_cnt");
        expect_val(S_WBD, 32'hDEAD_BEEF, "load_wbdata");
        expect_val(S_WBEN, 32'h1, "load_en");
        expect_val(S_RT, BYP ? 32'hDEAD_BEEF : 32'h0, "load_rt_same_cycle");

        // Write to R0 is discarded
        drive(0, 2'b10, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 7);
        expect_val(S_WBEN, 32'h0, "r0_en");
        expect_val(S_RS, 32'h0, "r0_rs");
        expect_val(S_RT, 32'hDEAD_BEEF, "load_r7");
        expect_val(S_CNT, 32'h2, "load_cnt");

        // Disabled write to r3
        drive(0, 2'b00, 3, 32'h55, 32'h55, 3, 0);
        expect_val(S_WBEN, 32'h0, "dis_en");
        expect_val(S_RS, 32'h0, "dis_r3_before");
        expect_val(S_RT, 32'h0, "r0_after_write");
        expect_val(S_CNT, 32'h2, "r0_cnt");

        drive(0, 2'b00, 0, 0, 0, 3, 0);
        expect_val(S_RS, 32'h0, "dis_r3_after");
        expect_val(S_CNT, 32'h2, "dis_cnt");

        // Same-cycle read/write of r9: old 1, new A5A5A5A5
        drive(0, 2'b10, 9, 32'h1, 32'h0, 0, 0);
        drive(0, 2'b10, 9, 32'hA5A5_A5A5, 32'h0, 9, 9);
        expect_val(S_RS, BYP ? 32'hA5A5_A5A5 : 32'h1, "rw_rs_same");
        expect_val(S_RT, BYP ? 32'hA5A5_A5A5 : 32'h1, "rw_rt_same");
        expect_val(S_CNT, 32'h3, "rw_cnt_mid");
        drive(0, 2'b00, 0, 0, 0, 9, 9);
        expect_val(S_RS, 32'hA5A5_A5A5, "rw_rs_next");
        expect_val(S_RT, 32'hA5A5_A5A5, "rw_rt_next");
        expect_val(S_CNT, 32'h4, "rw_cnt");

        // Reset mid-operation with a pending write; checked before any clock edge
        drive(1, 2'b10, 5, 32'h77, 32'h0, 5, 9);
        expect_val(S_RS, 32'h0, "midrst_rs");
        expect_val(S_RT, 32'h0, "midrst_rt");
        expect_val(S_CNT, 32'h0, "midrst_cnt");
        drive(0, 2'b10, 5, 32'h88, 32'h0, 9, 7);
        expect_val(S_RS, 32'h0, "postrst_r9");
        expect_val(S_RT, 32'h0, "postrst_r7");
        expect_val(S_CNT, 32'h0, "postrst_lost");
        drive(0, 2'b00, 0, 0, 0, 5, 0);
        expect_val(S_RS, 32'h88, "postrst_first_write");
        expect_val(S_CNT, 32'h1, "postrst_cnt");

        // Counter wrap with a 4-bit counter: 17 consecutive writes
        drive(1, 2'b00, 0, 0, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            drive(0, 2'b11, 5'((k % 31) + 1), 32'h0, 32'(k + 100), 0, 0);
            expect_val(S_CNT, 32'(k % 16), $sformatf("wrap_cnt_%0d", k));
        end
        drive(0, 2'b00, 0, 0, 0, 17, 1);
        expect_val(S_CNT, 32'h1, "wrap_cnt_end");
        expect_val(S_RS, 32'd116, "wrap_r17");
        expect_val(S_RT, 32'd100, "wrap_r1");

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q_sig.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_sig.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
